// File: rtl/pc_seq_pkg.sv
// Shared state encoding and PC arithmetic constants for the LEGv8 fetch sequencer.
package pc_seq_pkg;

    localparam logic [2:0] LOAD  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] EXEC  = 3'd3;
    localparam logic [2:0] HALT  = 3'd4;

    typedef enum logic [2:0] {
        ST_LOAD  = LOAD,
        ST_FETCH = FETCH,
        ST_WAIT  = WAIT,
        ST_EXEC  = EXEC,
        ST_HALT  = HALT
    } state_e;

    localparam int PC_INCR  = 4;
    localparam int BR_SHIFT = 2;

endpackage

// File: rtl/pc_fetch_sequencer_nextpc.sv
// NextPClogic: resolves the PC following an executed instruction from the
// branch, zero and unconditional-branch controls.
module NextPClogic
    import pc_seq_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0] current_pc,
    input  logic [PC_W-1:0] sign_ext_imm,
    input  logic            branch,
    input  logic            alu_zero,
    input  logic            uncondbranch,
    output logic [PC_W-1:0] next_pc
);

    logic            take;
    logic [PC_W-1:0] offset;

    // Word offset shifted to bytes; the top bits fall off and the sum wraps.
    always_comb begin
        take    = (branch & alu_zero) | uncondbranch;
        offset  = take ? (sign_ext_imm << BR_SHIFT) : PC_W'(PC_INCR);
        next_pc = current_pc + offset;
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch/PC controller: sequences req/ack instruction fetches and
// resolves the next PC. Optional macro PC_ALIGN_CHECK_EN faults on misaligned targets.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            CLK,
    input  logic            Reset_L,
    input  logic [PC_W-1:0] StartPC,
    input  logic            Halt,
    input  logic            Stall,
    input  logic            Branch,
    input  logic            ALUZero,
    input  logic            Uncondbranch,
    input  logic [PC_W-1:0] SignExtImm64,
    input  logic            IMemAck,
    input  logic [31:0]     IMemData,
    output logic [PC_W-1:0] CurrentPC,
    output logic            IMemReq,
    output logic [PC_W-1:0] IMemAddr,
    output logic [31:0]     Instruction,
    output logic            InstrValid,
    output logic            Halted,
    output logic            Fault
);

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     instr_q, instr_d;
    logic            req_q, req_d;
    logic            fault_q, fault_d;
    logic [PC_W-1:0] next_pc;

    NextPClogic #(.PC_W(PC_W)) u_next_pc (
        .current_pc   (pc_q),
        .sign_ext_imm (SignExtImm64),
        .branch       (Branch),
        .alu_zero     (ALUZero),
        .uncondbranch (Uncondbranch),
        .next_pc      (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        req_d   = req_q;
        fault_d = fault_q;
        case (state_q)
            ST_LOAD: begin
                pc_d    = StartPC;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                req_d   = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // An ack arriving on the final allowed cycle still wins over the timeout.
                if (IMemAck) begin
                    instr_d = IMemData;
                    req_d   = 1'b0;
                    state_d = ST_EXEC;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == TIMEOUT_CNT) begin
                        fault_d = 1'b1;
                        req_d   = 1'b0;
                        state_d = ST_HALT;
                    end
                end
            end
            ST_EXEC: begin
                if (Halt) begin
                    state_d = ST_HALT;
                end else if (!Stall) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
`else
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_HALT: begin
                req_d = 1'b0;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= ST_LOAD;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            instr_q <= '0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    assign CurrentPC   = pc_q;
    assign IMemAddr    = pc_q;
    assign IMemReq     = req_q;
    assign Instruction = instr_q;
    assign InstrValid  = (state_q == ST_EXEC);
    assign Halted      = (state_q == ST_HALT);
    assign Fault       = fault_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_pc_fetch_sequencer;

    localparam int TIMEOUT = 15;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic [63:0] StartPC = '0;
    logic        Halt = 1'b0;
    logic        Stall = 1'b0;
    logic        Branch = 1'b0;
    logic        ALUZero = 1'b0;
    logic        Uncondbranch = 1'b0;
    logic [63:0] SignExtImm64 = '0;
    logic        IMemAck = 1'b0;
    logic [31:0] IMemData = '0;
    logic [63:0] CurrentPC;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        Halted;
    logic        Fault;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_on = 1'b0;

    pc_fetch_sequencer #(.PC_W(64), .RESET_PC(64'h0), .TIMEOUT(TIMEOUT)) dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .StartPC      (StartPC),
        .Halt         (Halt),
        .Stall        (Stall),
        .Branch       (Branch),
        .ALUZero      (ALUZero),
        .Uncondbranch (Uncondbranch),
        .SignExtImm64 (SignExtImm64),
        .IMemAck      (IMemAck),
        .IMemData     (IMemData),
        .CurrentPC    (CurrentPC),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .Instruction  (Instruction),
        .InstrValid   (InstrValid),
        .Halted       (Halted),
        .Fault        (Fault)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: phase of the fetch/execute cycle plus architectural values.
    typedef enum int { M_LOAD, M_FETCH, M_WAIT, M_EXEC, M_HALT } mphase_t;
    mphase_t     m_phase = M_LOAD;
    logic [63:0] m_pc    = '0;
    logic [31:0] m_instr = '0;
    logic        m_req   = 1'b0;
    logic        m_fault = 1'b0;
    int          m_waited = 0;

    function automatic logic [63:0] branch_target(input logic [63:0] pc, input logic [63:0] imm,
                                                  input logic br, input logic z, input logic ub);
        logic [63:0] byte_off;
        byte_off = {imm[61:0], 2'b00};
        if ((br && z) || ub) return pc + byte_off;
        return pc + 64'd4;
    endfunction

    always @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            m_phase  <= M_LOAD;
            m_pc     <= 64'h0;
            m_instr  <= '0;
            m_req    <= 1'b0;
            m_fault  <= 1'b0;
            m_waited <= 0;
        end else begin
            case (m_phase)
                M_LOAD: begin
                    m_pc <= StartPC;
                    m_phase <= M_FETCH;
                end
                M_FETCH: begin
                    m_req <= 1'b1;
                    m_waited <= 0;
                    m_phase <= M_WAIT;
                end
                M_WAIT: begin
                    if (IMemAck) begin
                        m_instr <= IMemData;
                        m_req <= 1'b0;
                        m_phase <= M_EXEC;
                    end else if (m_waited + 1 >= TIMEOUT) begin
                        m_fault <= 1'b1;
                        m_req <= 1'b0;
                        m_phase <= M_HALT;
                    end else begin
                        m_waited <= m_waited + 1;
                    end
                end
                M_EXEC: begin
                    if (Halt) m_phase <= M_HALT;
                    else if (!Stall) begin
`ifdef PC_ALIGN_CHECK_EN
                        if (branch_target(m_pc, SignExtImm64, Branch, ALUZero, Uncondbranch) % 4 != 0) begin
                            m_fault <= 1'b1;
                            m_phase <= M_HALT;
                        end else begin
                            m_pc <= branch_target(m_pc, SignExtImm64, Branch, ALUZero, Uncondbranch);
                            m_phase <= M_FETCH;
                        end
`else
                        m_pc <= branch_target(m_pc, SignExtImm64, Branch, ALUZero, Uncondbranch);
                        m_phase <= M_FETCH;
`endif
                    end
                end
                default: m_phase <= M_HALT;
            endcase
        end
    end

    always @(negedge CLK) begin
        if (model_on) begin
            checkOutput("model_pc",     CurrentPC,   m_pc);
            checkOutput("model_addr",   IMemAddr,    m_pc);
            checkOutput("model_req",    64'(IMemReq), 64'(m_req));
            checkOutput("model_instr",  64'(Instruction), 64'(m_instr));
            checkOutput("model_valid",  64'(InstrValid), 64'(m_phase == M_EXEC));
            checkOutput("model_halted", 64'(Halted), 64'(m_phase == M_HALT));
            checkOutput("model_fault",  64'(Fault), 64'(m_fault));
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        Halt = 0; Stall = 0; Branch = 0; ALUZero = 0; Uncondbranch = 0;
        SignExtImm64 = '0; IMemAck = 0; IMemData = '0;
    endtask

    // Leaves the DUT in its FETCH cycle with StartPC loaded.
    task automatic do_reset(input logic [63:0] start);
        Reset_L = 0;
        clear_inputs();
        StartPC = start;
        tick();
        tick();
        Reset_L = 1;
        tick();
    endtask

    // From FETCH: d cycles without ack, then ack on the next WAIT cycle.
    task automatic fetch(input int d, input logic [31:0] data);
        tick();
        IMemAck = 0;
        repeat (d) tick();
        IMemAck = 1;
        IMemData = data;
        tick();
        IMemAck = 0;
    endtask

    task automatic applyStimulus(input int ack_pct);
        IMemAck = ($urandom_range(0, 99) < ack_pct);
        IMemData = $urandom;
        Halt = ($urandom_range(0, 99) < 3);
        Stall = ($urandom_range(0, 99) < 25);
        Branch = $urandom_range(0, 1);
        ALUZero = $urandom_range(0, 1);
        Uncondbranch = ($urandom_range(0, 99) < 20);
        if ($urandom_range(0, 1) == 1) SignExtImm64 = 64'(int'($urandom_range(0, 64)) - 32);
        else SignExtImm64 = {$urandom, $urandom};
    endtask

    initial begin
        Reset_L = 0;
        StartPC = 64'h100;
        tick();
        model_on = 1'b1;
        tick();
        checkOutput("rst_pc", CurrentPC, 64'h0);
        checkOutput("rst_req", 64'(IMemReq), 64'h0);
        checkOutput("rst_instr", 64'(Instruction), 64'h0);
        checkOutput("rst_valid_halt_fault", {61'h0, InstrValid, Halted, Fault}, 64'h0);

        // Basic fetch from StartPC 0x100
        Reset_L = 1;
        tick();
        checkOutput("load_pc", CurrentPC, 64'h100);
        checkOutput("load_req", 64'(IMemReq), 64'h0);
        tick();
        checkOutput("wait_req", 64'(IMemReq), 64'h1);
        checkOutput("wait_addr", IMemAddr, 64'h100);
        IMemAck = 1; IMemData = 32'hA5A5_0001;
        tick();
        IMemAck = 0;
        checkOutput("exec_valid", 64'(InstrValid), 64'h1);
        checkOutput("exec_instr", 64'(Instruction), 64'hA5A5_0001);
        checkOutput("exec_req", 64'(IMemReq), 64'h0);
        tick();
        checkOutput("seq_addr", IMemAddr, 64'h104);
        checkOutput("seq_valid", 64'(InstrValid), 64'h0);

        // Branch resolution from 0x200
        do_reset(64'h200); fetch(0, 32'h1);
        Branch = 1; ALUZero = 1; SignExtImm64 = -64'sd2;
        tick();
        checkOutput("br_taken", CurrentPC, 64'h1F8);
        do_reset(64'h200); fetch(1, 32'h2);
        Branch = 1; ALUZero = 0; SignExtImm64 = -64'sd2;
        tick();
        checkOutput("br_not_taken", CurrentPC, 64'h204);
        do_reset(64'h200); fetch(2, 32'h3);
        Uncondbranch = 1; SignExtImm64 = 64'd3;
        tick();
        checkOutput("uncond", CurrentPC, 64'h20C);

        // Stall holds EXEC
        do_reset(64'h300); fetch(0, 32'h4);
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_valid", 64'(InstrValid), 64'h1);
            checkOutput("stall_req", 64'(IMemReq), 64'h0);
            tick();
        end
        checkOutput("stall_pc_held", CurrentPC, 64'h300);
        checkOutput("stall_valid4", 64'(InstrValid), 64'h1);
        Stall = 0;
        tick();
        checkOutput("stall_release_pc", CurrentPC, 64'h304);
        checkOutput("stall_release_valid", 64'(InstrValid), 64'h0);

        // Timeout with no ack
        do_reset(64'h400);
        tick();
        repeat (TIMEOUT - 1) tick();
        checkOutput("to_pre_fault", 64'(Fault), 64'h0);
        checkOutput("to_pre_req", 64'(IMemReq), 64'h1);
        tick();
        checkOutput("to_fault", 64'(Fault), 64'h1);
        checkOutput("to_halted", 64'(Halted), 64'h1);
        checkOutput("to_req", 64'(IMemReq), 64'h0);
        IMemAck = 1; IMemData = 32'hDEAD_BEEF;
        tick(); tick();
        IMemAck = 0;
        checkOutput("to_ack_ignored", 64'(Instruction), 64'h0);
        checkOutput("to_still_halted", 64'(Halted), 64'h1);

        // Ack on the last allowed WAIT cycle
        do_reset(64'h480); fetch(TIMEOUT - 1, 32'hCAFE_0015);
        checkOutput("late_ack_valid", 64'(InstrValid), 64'h1);
        checkOutput("late_ack_fault", 64'(Fault), 64'h0);
        checkOutput("late_ack_instr", 64'(Instruction), 64'hCAFE_0015);

        // Halt beats Stall
        do_reset(64'h500); fetch(0, 32'h5);
        Halt = 1; Stall = 1; Uncondbranch = 1; SignExtImm64 = 64'd8;
        tick(); tick();
        checkOutput("halt_halted", 64'(Halted), 64'h1);
        checkOutput("halt_pc", CurrentPC, 64'h500);

        // Asynchronous reset in the middle of WAIT
        do_reset(64'h600);
        tick();
        checkOutput("midwait_req", 64'(IMemReq), 64'h1);
        #1 Reset_L = 0;
        #1;
        checkOutput("async_req", 64'(IMemReq), 64'h0);
        checkOutput("async_pc", CurrentPC, 64'h0);

        // Misaligned start address
        do_reset(64'h102); fetch(0, 32'h6);
        tick();
`ifdef PC_ALIGN_CHECK_EN
        checkOutput("misalign_fault", 64'(Fault), 64'h1);
        checkOutput("misalign_halted", 64'(Halted), 64'h1);
        checkOutput("misalign_pc", CurrentPC, 64'h102);
`else
        checkOutput("misalign_pc", IMemAddr, 64'h106);
        checkOutput("misalign_fault", 64'(Fault), 64'h0);
`endif

        // Randomized traffic
        for (int ep = 0; ep < 40; ep++) begin
            logic [63:0] start;
            int ack_pct;
            start = {32'h0, $urandom} & ~64'h3;
            if ($urandom_range(0, 7) == 0) start[1:0] = 2'($urandom_range(1, 3));
            ack_pct = (ep % 5 == 0) ? 5 : 40;
            do_reset(start);
            for (int c = 0; c < 200; c++) begin
                applyStimulus(ack_pct);
                tick();
            end
        end

        clear_inputs();
        tick();
        model_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Multi-cycle fetch/PC controller for the LEGv8 core.
- Owns the program counter and sequences instruction-memory fetches over a req/ack handshake.
- Presents each fetched instruction for one execute cycle, then resolves the next PC from branch/zero/unconditional-branch controls.
- Replaces the free-running PC register so the core tolerates a slow instruction memory.

Parameters:
- PC_W, 64, width of PC and immediate.
- RESET_PC, 64'h0, PC value held while Reset_L is low.
- TIMEOUT, 15, maximum WAIT cycles before a fetch fault (4-bit counter, 1..15).

Ports:
- CLK  input  1  single clock, rising edge.
- Reset_L  input  1  asynchronous active-low reset.
- StartPC  input  PC_W  PC loaded in the first cycle after reset release.
- Halt  input  1  request to stop; honoured in EXEC.
- Stall  input  1  hold in EXEC (datapath not ready).
- Branch  input  1  conditional-branch control, sampled in EXEC.
- ALUZero  input  1  ALU zero flag, sampled in EXEC.
- Uncondbranch  input  1  unconditional-branch control, sampled in EXEC.
- SignExtImm64  input  PC_W  sign-extended word offset, sampled in EXEC.
- IMemAck  input  1  instruction memory data valid.
- IMemData  input  32  instruction word.
- CurrentPC  output  PC_W  registered PC.
- IMemReq  output  1  fetch request, registered.
- IMemAddr  output  PC_W  equals CurrentPC.
- Instruction  output  32  last fetched word, registered.
- InstrValid  output  1  high in EXEC cycles.
- Halted  output  1  high in HALT.
- Fault  output  1  sticky fault flag.

Behaviour:
- Reset (Reset_L low, asynchronous): state LOAD, CurrentPC=RESET_PC, Instruction=0, IMemReq=0, InstrValid=0, Halted=0, Fault=0, wait counter=0.
- LOAD: CurrentPC<=StartPC, go FETCH. Takes 1 cycle.
- FETCH: IMemReq=1 and counter cleared. Go WAIT.
- WAIT:
  - IMemReq stays 1.
  - If IMemAck: Instruction<=IMemData, IMemReq<=0, go EXEC.
  - Else counter increments. When counter reaches TIMEOUT without ack: Fault<=1, IMemReq<=0, go HALT.
  - Ack in the same cycle the counter reaches TIMEOUT: ack wins, no fault.
- Minimum fetch latency: FETCH→EXEC is 2 cycles with an immediate ack.
- EXEC: InstrValid=1.
  - Halt has priority over Stall: go HALT, PC unchanged.
  - Else if Stall: remain in EXEC, PC and Instruction unchanged.
  - Else take = (Branch & ALUZero) | Uncondbranch.
    - take=1: CurrentPC <= CurrentPC + (SignExtImm64 << 2).
    - take=0: CurrentPC <= CurrentPC + 4.
    - Then go FETCH.
- Arithmetic: modulo 2^PC_W, wrap-around silently; the shift discards the top 2 bits of the immediate.
- HALT: Halted=1, IMemReq=0, absorbing state; exited only by reset.
- IMemAck outside WAIT is ignored.
- Reset mid-fetch drops IMemReq immediately; the memory must discard the pending request.
- All outputs are registered except IMemAddr (a wire to CurrentPC) and InstrValid/Halted (decoded from state register).

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined: in EXEC, if the computed next PC has bits [1:0] != 0, set Fault=1, leave CurrentPC unchanged, go HALT.
- Undefined: no check; a misaligned target is fetched as-is. With default inputs this can only arise from StartPC misalignment.

Decomposition:
- Shared package pc_seq_pkg:
  - State encoding localparams LOAD, FETCH, WAIT, EXEC, HALT (3 bits).
  - Constant PC_INCR=4.
  - Constant BR_SHIFT=2.
- Natural sub-module: the existing NextPClogic, instantiated for the EXEC next-PC computation. The FSM holds only the state, PC, and counter registers.

Test Plan:
- Reset release with StartPC=64'h100, IMemAck one cycle after req → CurrentPC=0x100, InstrValid pulse, then IMemAddr=0x104.
- EXEC at PC=0x200, Branch=1, ALUZero=1, SignExtImm64=-2 → next CurrentPC=0x1F8. With ALUZero=0 → 0x204. With Uncondbranch=1, imm=3 → 0x20C.
- Stall high 3 cycles in EXEC, then low → InstrValid high 3+1 cycles, single PC update, no extra IMemReq.
- IMemAck withheld for TIMEOUT cycles → Fault=1, Halted=1, IMemReq=0; later IMemAck has no effect. Ack on exactly cycle 15 → normal EXEC, Fault=0.
- Halt and Stall both high in EXEC → HALT next cycle, PC frozen. Reset_L pulsed low mid-WAIT → IMemReq drops asynchronously, CurrentPC=RESET_PC.
- With PC_ALIGN_CHECK_EN and StartPC=0x102 → first EXEC sets Fault, HALT, CurrentPC stays 0x102. Without the macro → next fetch at 0x106.
